beam_power_acc: RTL

- Upstream feeder of the beam sorting stage.
- Computes per-beam power I²+Q² for all COL beams on every resource element (RE).
- Accumulates the power over one resource block group (RBG) of RE_PER_RBG REs.
- Presents the COL scaled, saturated power sums, one vector per RBG, with valid/last/enable strobes that the sorter consumes directly.

---
 rtl/beam_power_acc_if.sv | 27 ++
 rtl/beam_power_acc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/beam_power_acc_if.sv
// Sample-in / RBG-power-out bundle between the beamformer, the power accumulator and the beam sorter.
// The parameters must match those of the beam_power_acc instance this bundle is attached to.
interface beam_power_acc_if #(
   parameter int DW  = 16,
   parameter int COL = 64,
   parameter int OW  = 32
);
   logic [COL-1:0][2*DW-1:0] i_data;
   logic                     i_valid;
   logic                     i_sop;
   logic                     i_eop;
   logic [COL-1:0][OW-1:0]   o_data;
   logic                     o_rvalid;
   logic                     o_rready;
   logic                     o_enable;
   logic [5:0]               o_rbg_num;

   modport master (
      output i_data, i_valid, i_sop, i_eop,
      input  o_data, o_rvalid, o_rready, o_enable, o_rbg_num
   );

   modport slave (
      input  i_data, i_valid, i_sop, i_eop,
      output o_data, o_rvalid, o_rready, o_enable, o_rbg_num
   );
endinterface

// File: rtl/beam_power_acc.sv
// Per-beam I^2+Q^2 accumulated over one RBG of REs; emits one scaled, saturated power vector per RBG
// with the valid/last/enable strobes the beam sorter consumes.
module beam_power_lane #(
   parameter int DW    = 16,
   parameter int AW    = 39,
   parameter int SHIFT = 6,
   parameter int OW    = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [2*DW-1:0] data_i,
   input  logic            acc_en_i,
   input  logic            load_i,
   input  logic            cap_i,
   output logic [OW-1:0]   pwr_o
);
   logic signed [2*DW-1:0] i_x, q_x, pi_q, pq_q;
   logic [2*DW:0]          sum_q;
   logic [AW-1:0]          acc_q, acc_d, shf;
   logic [OW-1:0]          pwr_q, sat_d;

   assign i_x = {{DW{data_i[2*DW-1]}}, data_i[2*DW-1:DW]};
   assign q_x = {{DW{data_i[DW-1]}}, data_i[DW-1:0]};

   // Output is taken from the next accumulator value so it already includes the triggering RE.
   assign acc_d = load_i ? AW'(sum_q) : acc_q + AW'(sum_q);
   assign shf   = acc_d >> SHIFT;

   generate
      if (AW > OW) begin : g_sat
         assign sat_d = (|shf[AW-1:OW]) ? '1 : shf[OW-1:0];
      end else begin : g_nosat
         assign sat_d = OW'(shf);
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pi_q  <= '0;
         pq_q  <= '0;
         sum_q <= '0;
         acc_q <= '0;
         pwr_q <= '0;
      end else begin
         pi_q  <= i_x * i_x;
         pq_q  <= q_x * q_x;
         sum_q <= {1'b0, pi_q} + {1'b0, pq_q};
         if (acc_en_i) acc_q <= acc_d;
         if (cap_i)    pwr_q <= sat_d;
      end
   end

   assign pwr_o = pwr_q;
endmodule

module beam_power_acc #(
   parameter int DW         = 16,
   parameter int COL        = 64,
   parameter int RE_PER_RBG = 48,
   parameter int AW         = 39,
   parameter int SHIFT      = 6,
   parameter int OW         = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   beam_power_acc_if.slave  bus
);
   localparam logic [7:0] RE_LAST = 8'(RE_PER_RBG - 1);

   logic [2:1] vld_pipe_q, sop_pipe_q, eop_pipe_q;
   logic [7:0] re_cnt_q, re_cnt_d, re_idx;
   logic [5:0] rbg_cnt_q, rbg_cnt_d, rbg_idx;
   logic       s2_vld, s2_sop, s2_eop, load, trig;
   logic       o_rvalid_q, o_rready_q, o_enable_q, sop_pend_q;
   logic [5:0] o_rbg_q;
   logic [COL-1:0][OW-1:0] pwr;

   assign s2_vld  = vld_pipe_q[2];
   assign s2_sop  = s2_vld & sop_pipe_q[2];
   assign s2_eop  = s2_vld & eop_pipe_q[2];

   // A sop re-bases both counters, discarding whatever RBG was in flight.
   assign re_idx  = s2_sop ? 8'd0 : re_cnt_q;
   assign rbg_idx = s2_sop ? 6'd0 : rbg_cnt_q;
   assign load    = (re_idx == 8'd0);
   assign trig    = s2_vld & ((re_idx == RE_LAST) | s2_eop);

   always_comb begin
      re_cnt_d  = re_cnt_q;
      rbg_cnt_d = rbg_cnt_q;
      if (s2_vld) re_cnt_d = trig ? 8'd0 : re_idx + 8'd1;
      if (s2_sop) rbg_cnt_d = 6'd0;
      if (trig)   rbg_cnt_d = s2_eop ? 6'd0 : rbg_idx + 6'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         vld_pipe_q <= '0;
         sop_pipe_q <= '0;
         eop_pipe_q <= '0;
         re_cnt_q   <= '0;
         rbg_cnt_q  <= '0;
         o_rvalid_q <= 1'b0;
         o_rready_q <= 1'b0;
         o_enable_q <= 1'b0;
         sop_pend_q <= 1'b0;
         o_rbg_q    <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[1], bus.i_valid};
         sop_pipe_q <= {sop_pipe_q[1], bus.i_valid & bus.i_sop};
         eop_pipe_q <= {eop_pipe_q[1], bus.i_valid & bus.i_eop};
         re_cnt_q   <= re_cnt_d;
         rbg_cnt_q  <= rbg_cnt_d;
         o_rvalid_q <= trig;
         o_rready_q <= trig & s2_eop;
         if (trig) o_rbg_q <= rbg_idx;
         // A sop landing on the drop cycle is held one cycle so the sorter sees enable low between symbols.
         if (o_rready_q) begin
            o_enable_q <= 1'b0;
            sop_pend_q <= s2_sop;
         end else if (s2_sop | sop_pend_q) begin
            o_enable_q <= 1'b1;
            sop_pend_q <= 1'b0;
         end
      end
   end

   generate
      for (genvar b = 0; b < COL; b++) begin : g_lane
         beam_power_lane #(.DW(DW), .AW(AW), .SHIFT(SHIFT), .OW(OW)) u_lane (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .data_i   (bus.i_data[b]),
            .acc_en_i (s2_vld),
            .load_i   (load),
            .cap_i    (trig),
            .pwr_o    (pwr[b])
         );
      end
   endgenerate

   assign bus.o_data    = pwr;
   assign bus.o_rvalid  = o_rvalid_q;
   assign bus.o_rready  = o_rready_q;
   assign bus.o_enable  = o_enable_q;
   assign bus.o_rbg_num = o_rbg_q;
endmodule
